// File: rtl/dec_to_hex.sv
// rtl/dec_to_hex.sv - sequential BCD-digit vector to unsigned binary converter
module dec_to_hex #(
    parameter int NUM_DIGITS = 5,
    parameter int OUT_W      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [NUM_DIGITS-1:0][7:0] dec_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [OUT_W-1:0]           hex_o,
    output logic                       ovf_o,
    output logic                       err_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ACC_W = OUT_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [NUM_DIGITS-1:0][7:0]  dig_q, dig_d;
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        ovf_q, ovf_d;
    logic                        err_q, err_d;
    logic [OUT_W-1:0]            hex_q, hex_d;
    logic                        ovf_out_q, ovf_out_d;
    logic                        err_out_q, err_out_d;
    logic                        done_q, done_d;

    logic [7:0]                  cur_digit;
    logic                        digit_bad;
    logic [ACC_W-1:0]            acc_step;
    logic                        step_ovf;

    // The accumulator is below 2^OUT_W before every step, so the four
    // spare bits absorb acc*10+9 without wrapping.
    always_comb begin
        cur_digit = dig_q[idx_q];
        digit_bad = (cur_digit[7:4] != 4'd0) || (cur_digit[3:0] > 4'd9);
        acc_step  = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_digit[3:0]);
        step_ovf  = |acc_step[ACC_W-1:OUT_W];
    end

    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        hex_d     = hex_q;
        ovf_out_d = ovf_out_q;
        err_out_d = err_out_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dig_d   = dec_i;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = IDX_W'(NUM_DIGITS - 1);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (digit_bad) begin
                    err_d = 1'b1;
                end else if (!ovf_q) begin
                    acc_d = acc_step;
                    if (step_ovf) begin
                        ovf_d = 1'b1;
                    end
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (err_q) begin
                    hex_d     = '0;
                    err_out_d = 1'b1;
                    ovf_out_d = 1'b0;
                end else if (ovf_q) begin
                    hex_d     = '1;
                    err_out_d = 1'b0;
                    ovf_out_d = 1'b1;
                end else begin
                    hex_d     = acc_q[OUT_W-1:0];
                    err_out_d = 1'b0;
                    ovf_out_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            dig_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            hex_q     <= '0;
            ovf_out_q <= 1'b0;
            err_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            hex_q     <= hex_d;
            ovf_out_q <= ovf_out_d;
            err_out_q <= err_out_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign hex_o  = hex_q;
    assign ovf_o  = ovf_out_q;
    assign err_o  = err_out_q;

endmodule

// File: tb/tb_dec_to_hex.sv
// tb/tb_dec_to_hex.sv - self-checking bench for dec_to_hex
module tb_dec_to_hex;

    localparam int ND = 5;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [ND-1:0][7:0]   dec = '0;
    logic                 busy;
    logic                 done;
    logic [OW-1:0]        hex;
    logic                 ovf;
    logic                 err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    dec_to_hex #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .dec_i   (dec),
        .busy_o  (busy),
        .done_o  (done),
        .hex_o   (hex),
        .ovf_o   (ovf),
        .err_o   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ND-1:0][7:0] mk(input int d4, input int d3, input int d2,
                                              input int d1, input int d0);
        logic [ND-1:0][7:0] r;
        r[4] = d4[7:0];
        r[3] = d3[7:0];
        r[2] = d2[7:0];
        r[1] = d1[7:0];
        r[0] = d0[7:0];
        return r;
    endfunction

    // Reference: decimal value by positional weights, then classify.
    task automatic model(input logic [ND-1:0][7:0] d, output logic [OW-1:0] h,
                         output logic o, output logic e);
        longint v;
        longint p;
        v = 0;
        p = 1;
        e = 1'b0;
        for (int k = 0; k < ND; k++) begin
            if (d[k] > 8'd9) e = 1'b1;
            v += longint'(d[k]) * p;
            p *= 10;
        end
        if (e) begin
            h = '0;
            o = 1'b0;
        end else if (v > ((longint'(1) << OW) - 1)) begin
            h = '1;
            o = 1'b1;
        end else begin
            h = v[OW-1:0];
            o = 1'b0;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the done edge.
    task automatic do_conv(input logic [ND-1:0][7:0] d, output int lat, output logic [OW-1:0] h,
                           output logic o, output logic e, output int busy_n);
        dec = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        busy_n = 0;
        if (busy) busy_n++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
        end
        h = hex;
        o = ovf;
        e = err;
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (hex !== 16'h0) begin bad++; $display("FAIL reset_hex got=%h want=0000", hex); end
        total++; if ({ovf, err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {ovf, err}); end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        int lat, bn;
        logic [OW-1:0] h;
        logic o, e;
        do_conv(mk(1, 2, 3, 4, 5), lat, h, o, e, bn);
        total++; if (lat !== 6) begin bad++; $display("FAIL basic_latency got=%0d want=6", lat); end
        total++; if (h !== 16'h3039) begin bad++; $display("FAIL basic_hex got=%h want=3039", h); end
        total++; if ({o, e} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b want=00", {o, e}); end
        total++; if (bn !== 6) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=6", bn); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_boundary();
        logic [ND-1:0][7:0] vec [4];
        logic [OW-1:0]      exp_h [4];
        logic               exp_o [4];
        int lat, bn;
        logic [OW-1:0] h;
        logic o, e;
        vec[0] = mk(6, 5, 5, 3, 5); exp_h[0] = 16'hFFFF; exp_o[0] = 1'b0;
        vec[1] = mk(6, 5, 5, 3, 6); exp_h[1] = 16'hFFFF; exp_o[1] = 1'b1;
        vec[2] = mk(9, 9, 9, 9, 9); exp_h[2] = 16'hFFFF; exp_o[2] = 1'b1;
        vec[3] = mk(0, 0, 0, 0, 0); exp_h[3] = 16'h0000; exp_o[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_conv(vec[i], lat, h, o, e, bn);
            total++; if (lat !== 6) begin bad++; $display("FAIL boundary%0d_latency got=%0d want=6", i, lat); end
            total++; if (h !== exp_h[i]) begin bad++; $display("FAIL boundary%0d_hex got=%h want=%h", i, h, exp_h[i]); end
            total++; if (o !== exp_o[i]) begin bad++; $display("FAIL boundary%0d_ovf got=%b want=%b", i, o, exp_o[i]); end
            total++; if (e !== 1'b0) begin bad++; $display("FAIL boundary%0d_err got=%b want=0", i, e); end
        end
    endtask

    task automatic test_illegal();
        logic [ND-1:0][7:0] vec [3];
        int lat, bn;
        logic [OW-1:0] h;
        logic o, e;
        vec[0] = mk(1, 2, 'h0A, 4, 5);
        vec[1] = mk(1, 2, 'h13, 4, 5);
        vec[2] = mk(9, 9, 9, 9, 'h0F);
        for (int i = 0; i < 3; i++) begin
            do_conv(vec[i], lat, h, o, e, bn);
            total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal%0d_err got=%b want=1", i, e); end
            total++; if (h !== 16'h0) begin bad++; $display("FAIL illegal%0d_hex got=%h want=0000", i, h); end
            total++; if (o !== 1'b0) begin bad++; $display("FAIL illegal%0d_ovf got=%b want=0", i, o); end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        logic [OW-1:0] h1;
        dec = mk(1, 2, 3, 4, 5);
        start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        dec = mk(0, 0, 0, 4, 2);
        t1 = -100;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin t1 = cyc; break; end
        end
        h1 = hex;
        total++; if (t1 - t0 !== 6) begin bad++; $display("FAIL b2b_first_latency got=%0d want=6", t1 - t0); end
        total++; if (h1 !== 16'h3039) begin bad++; $display("FAIL b2b_first_hex got=%h want=3039", h1); end
        @(posedge clk);
        #1 start = 1'b0;
        t2 = -100;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin t2 = cyc; break; end
        end
        total++; if (t2 - t1 !== 7) begin bad++; $display("FAIL b2b_interval got=%0d want=7", t2 - t1); end
        total++; if (hex !== 16'h002A) begin bad++; $display("FAIL b2b_second_hex got=%h want=002a", hex); end
    endtask

    task automatic test_mid_change();
        logic [ND-1:0][7:0] d;
        logic [OW-1:0] eh;
        logic eo, ee;
        int seen;
        d = mk(4, 3, 2, 1, 0);
        model(d, eh, eo, ee);
        dec = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            dec = mk($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 255),
                     $urandom_range(0, 9), $urandom_range(0, 9));
            @(posedge clk);
            #1;
            if (done) begin seen = 1; break; end
        end
        total++; if (seen !== 1) begin bad++; $display("FAIL midchg_done got=%0d want=1", seen); end
        total++; if ({hex, ovf, err} !== {eh, eo, ee}) begin
            bad++; $display("FAIL midchg_result got=%h/%b/%b want=%h/%b/%b", hex, ovf, err, eh, eo, ee);
        end
    endtask

    task automatic test_start_during_conv();
        int ndone, seen;
        dec = mk(1, 2, 3, 4, 5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        dec = mk(0, 0, 0, 0, 7);
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin seen = i; break; end
        end
        total++; if (seen !== 6) begin bad++; $display("FAIL ignstart_latency got=%0d want=6", seen); end
        total++; if (hex !== 16'h3039) begin bad++; $display("FAIL ignstart_hex got=%h want=3039", hex); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL ignstart_extra_done got=%0d want=0", ndone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignstart_busy got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        int lat, bn, ndone;
        logic [OW-1:0] h;
        logic o, e;
        do_conv(mk(6, 5, 5, 3, 6), lat, h, o, e, bn);
        total++; if ({h, o} !== {16'hFFFF, 1'b1}) begin bad++; $display("FAIL areset_pre got=%h/%b want=ffff/1", h, o); end
        dec = mk(0, 0, 1, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done got=%b want=0", done); end
        total++; if (hex !== 16'h0) begin bad++; $display("FAIL areset_hex got=%h want=0000", hex); end
        total++; if ({ovf, err} !== 2'b00) begin bad++; $display("FAIL areset_flags got=%b want=00", {ovf, err}); end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL areset_stray_done got=%0d want=0", ndone); end
        do_conv(mk(0, 0, 0, 4, 2), lat, h, o, e, bn);
        total++; if (lat !== 6) begin bad++; $display("FAIL areset_after_latency got=%0d want=6", lat); end
        total++; if ({h, o, e} !== {16'h002A, 2'b00}) begin
            bad++; $display("FAIL areset_after_result got=%h/%b/%b want=002a/0/0", h, o, e);
        end
    endtask

    task automatic test_random();
        logic [ND-1:0][7:0] d;
        logic [OW-1:0] eh, h;
        logic eo, ee, o, e;
        int lat, bn;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < ND; k++) d[k] = 8'($urandom_range(0, 9));
            if (n % 4 == 0) begin
                d[4] = 8'd6;
                d[3] = 8'd5;
            end
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, ND - 1)] = 8'($urandom_range(10, 255));
            model(d, eh, eo, ee);
            do_conv(d, lat, h, o, e, bn);
            total++; if (lat !== 6) begin bad++; $display("FAIL rand%0d_latency got=%0d want=6", n, lat); end
            total++; if (h !== eh) begin bad++; $display("FAIL rand%0d_hex in=%h got=%h want=%h", n, d, h, eh); end
            total++; if (o !== eo) begin bad++; $display("FAIL rand%0d_ovf in=%h got=%b want=%b", n, d, o, eo); end
            total++; if (e !== ee) begin bad++; $display("FAIL rand%0d_err in=%h got=%b want=%b", n, d, e, ee); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_illegal();
        test_back_to_back();
        test_mid_change();
        test_start_during_conv();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
